// File: rtl/dma_sched_pkg.sv
// Shared types and constants for the DMA burst scheduler family.
// Default widths match the standard 40-bit address, 128-bit data configuration.
package dma_sched_pkg;

    localparam int DEF_ADDR_BITS    = 40;
    localparam int DEF_BEAT_BITS    = 32;
    localparam int DEF_AXI_LEN_BITS = 8;
    localparam int DEF_SIZE         = 4;
    localparam int DEF_MAX_BURST    = 256;
    localparam int DEF_ISSUE_LIMIT  = 16;
    localparam int DEF_CNT_BITS     = 5;

    // AXI bursts may not cross a 4 KB page.
    localparam int                   BOUNDARY_BITS  = 12;
    localparam logic [BOUNDARY_BITS:0] BOUNDARY_BYTES = 13'h1000;

    typedef logic [DEF_ADDR_BITS-1:0]    adr_t;
    typedef logic [DEF_BEAT_BITS-1:0]    beats_t;
    typedef logic [DEF_AXI_LEN_BITS-1:0] axlen_t;
    typedef logic [DEF_CNT_BITS-1:0]     cnt_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_ISSUE = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/dma_burst_len_calc.sv
// Combinational burst sizing: min(remaining, MAX_BURST, beats left in the 4 KB page).
// Shared by the read- and write-side schedulers.
module dma_burst_len_calc
    import dma_sched_pkg::*;
#(
    parameter int BEAT_BITS = DEF_BEAT_BITS,
    parameter int SIZE      = DEF_SIZE,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic [BEAT_BITS-1:0]     remaining_i,
    input  logic [BOUNDARY_BITS-1:0] addr_low_i,
    output logic [BEAT_BITS-1:0]     burst_o
);

    logic [BOUNDARY_BITS:0] bnd_bytes;
    logic [BEAT_BITS-1:0]   bnd_beats;
    logic [BEAT_BITS-1:0]   cap;

    always_comb begin
        // addr_low_i is beat-aligned, so the shift is exact and never yields 0.
        bnd_bytes = BOUNDARY_BYTES - {1'b0, addr_low_i};
        bnd_beats = BEAT_BITS'(bnd_bytes >> SIZE);
        cap       = (bnd_beats < BEAT_BITS'(MAX_BURST)) ? bnd_beats : BEAT_BITS'(MAX_BURST);
        burst_o   = (remaining_i < cap) ? remaining_i : cap;
    end

endmodule

// File: rtl/dma_burst_scheduler.sv
// Splits one DMA job into AXI-legal bursts, issues them with an outstanding-burst
// limit, and signals job completion once every issued burst has been retired.
module dma_burst_scheduler
    import dma_sched_pkg::*;
#(
    parameter int ADDR_BITS    = DEF_ADDR_BITS,
    parameter int BEAT_BITS    = DEF_BEAT_BITS,
    parameter int AXI_LEN_BITS = DEF_AXI_LEN_BITS,
    parameter int SIZE         = DEF_SIZE,
    parameter int MAX_BURST    = DEF_MAX_BURST,
    parameter int ISSUE_LIMIT  = DEF_ISSUE_LIMIT,
    parameter int CNT_BITS     = DEF_CNT_BITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_BITS-1:0]    s_cmd_addr,
    input  logic [BEAT_BITS-1:0]    s_cmd_beats,
    input  logic                    s_cmd_valid,
    output logic                    s_cmd_ready,
    output logic [ADDR_BITS-1:0]    m_issue_addr,
    output logic [AXI_LEN_BITS-1:0] m_issue_len,
    output logic                    m_issue_valid,
    input  logic                    m_issue_ready,
    input  logic                    s_done_valid,
    output logic                    busy,
    output logic                    job_done,
    output logic [CNT_BITS-1:0]     issue_cnt
);

    state_e                  state_q, state_d;
    logic [ADDR_BITS-1:0]    cur_addr_q, cur_addr_d;
    logic [ADDR_BITS-1:0]    issue_addr_q, issue_addr_d;
    logic [AXI_LEN_BITS-1:0] issue_len_q, issue_len_d;
    logic [BEAT_BITS-1:0]    remaining_q, remaining_d;
    logic [BEAT_BITS-1:0]    burst_q, burst_d;
    logic [BEAT_BITS-1:0]    calc_burst;
    logic [CNT_BITS-1:0]     cnt_q, cnt_d;
    logic                    ready_q, ready_d;
    logic                    done_q, done_d;
    logic                    cmd_hs, issue_hs, can_issue, cnt_inc, cnt_dec;

    dma_burst_len_calc #(
        .BEAT_BITS (BEAT_BITS),
        .SIZE      (SIZE),
        .MAX_BURST (MAX_BURST)
    ) u_len_calc (
        .remaining_i (remaining_q),
        .addr_low_i  (cur_addr_q[BOUNDARY_BITS-1:0]),
        .burst_o     (calc_burst)
    );

    assign can_issue     = cnt_q < CNT_BITS'(ISSUE_LIMIT);
    assign m_issue_valid = (state_q == S_ISSUE) && can_issue;
    assign issue_hs      = m_issue_valid && m_issue_ready;
    assign cmd_hs        = s_cmd_valid && ready_q;

    // A completion with nothing outstanding is dropped unless it cancels a same-cycle issue.
    assign cnt_inc = issue_hs;
    assign cnt_dec = s_done_valid && ((cnt_q != '0) || cnt_inc);

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        remaining_d  = remaining_q;
        burst_d      = burst_q;
        issue_addr_d = issue_addr_q;
        issue_len_d  = issue_len_q;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_hs) begin
                    cur_addr_d  = {s_cmd_addr[ADDR_BITS-1:SIZE], {SIZE{1'b0}}};
                    remaining_d = s_cmd_beats;
                    state_d     = S_CALC;
                end
            end
            S_CALC: begin
                if (remaining_q == '0) begin
                    state_d = S_DRAIN;
                end else begin
                    issue_addr_d = cur_addr_q;
                    issue_len_d  = AXI_LEN_BITS'(calc_burst - 1'b1);
                    burst_d      = calc_burst;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue_hs) begin
                    cur_addr_d  = cur_addr_q + (ADDR_BITS'(burst_q) << SIZE);
                    remaining_d = remaining_q - burst_q;
                    state_d     = S_CALC;
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Ready is held low during the job_done cycle so it rises one cycle later.
        ready_d = (state_d == S_IDLE) && !done_d;

        cnt_d = cnt_q;
        if (cnt_inc && !cnt_dec) begin
            cnt_d = cnt_q + 1'b1;
        end else if (cnt_dec && !cnt_inc) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cur_addr_q   <= '0;
            remaining_q  <= '0;
            burst_q      <= '0;
            issue_addr_q <= '0;
            issue_len_q  <= '0;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            remaining_q  <= remaining_d;
            burst_q      <= burst_d;
            issue_addr_q <= issue_addr_d;
            issue_len_q  <= issue_len_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
        end
    end

    assign s_cmd_ready  = ready_q;
    assign m_issue_addr = issue_addr_q;
    assign m_issue_len  = issue_len_q;
    assign busy         = (state_q != S_IDLE);
    assign job_done     = done_q;
    assign issue_cnt    = cnt_q;

endmodule

// File: tb/tb_dma_burst_scheduler.sv
// Directed bench for dma_burst_scheduler (ISSUE_LIMIT=2): table of jobs with
// expected bursts, plus hand-written sequences for timing and corner cases.
module tb_dma_burst_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [39:0] s_cmd_addr;
    logic [31:0] s_cmd_beats;
    logic        s_cmd_valid;
    logic        s_cmd_ready;
    logic [39:0] m_issue_addr;
    logic [7:0]  m_issue_len;
    logic        m_issue_valid;
    logic        m_issue_ready;
    logic        s_done_valid;
    logic        busy;
    logic        job_done;
    logic [4:0]  issue_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    dma_burst_scheduler #(
        .ISSUE_LIMIT (2)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .s_cmd_addr    (s_cmd_addr),
        .s_cmd_beats   (s_cmd_beats),
        .s_cmd_valid   (s_cmd_valid),
        .s_cmd_ready   (s_cmd_ready),
        .m_issue_addr  (m_issue_addr),
        .m_issue_len   (m_issue_len),
        .m_issue_valid (m_issue_valid),
        .m_issue_ready (m_issue_ready),
        .s_done_valid  (s_done_valid),
        .busy          (busy),
        .job_done      (job_done),
        .issue_cnt     (issue_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [39:0]      addr;
        logic [31:0]      beats;
        int               n;
        logic [2:0][39:0] exp_addr;
        logic [2:0][7:0]  exp_len;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [39:0] addr, input logic [31:0] beats);
        int cyc = 0;
        while (!s_cmd_ready && cyc < 40) begin
            step();
            cyc++;
        end
        check("cmd_ready_timeout", 64'(s_cmd_ready), 64'd1);
        s_cmd_valid = 1'b1;
        s_cmd_addr  = addr;
        s_cmd_beats = beats;
        step();
        s_cmd_valid = 1'b0;
        $display("job accepted addr=0x%0h beats=%0d", addr, beats);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!m_issue_valid && cyc < 40) begin
            step();
            cyc++;
        end
        check("issue_valid_timeout", 64'(m_issue_valid), 64'd1);
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (!job_done && cyc < 40) begin
            step();
            cyc++;
        end
        check("job_done_timeout", 64'(job_done), 64'd1);
        check("cnt_at_done", 64'(issue_cnt), 64'd0);
        $display("job_done after %0d cycles of waiting", cyc);
    endtask

    task automatic done_pulse();
        s_done_valid = 1'b1;
        step();
        s_done_valid = 1'b0;
    endtask

    initial begin
        int cyc;

        vecs[0] = '{addr: 40'h1000, beats: 32'h100, n: 1,
                    exp_addr: {40'h0, 40'h0, 40'h1000}, exp_len: {8'h0, 8'h0, 8'hFF}};
        vecs[1] = '{addr: 40'h1F00, beats: 32'h40, n: 2,
                    exp_addr: {40'h0, 40'h2000, 40'h1F00}, exp_len: {8'h0, 8'h2F, 8'h0F}};
        vecs[2] = '{addr: 40'h0, beats: 32'd600, n: 3,
                    exp_addr: {40'h2000, 40'h1000, 40'h0}, exp_len: {8'h57, 8'hFF, 8'hFF}};
        vecs[3] = '{addr: 40'h3000, beats: 32'd0, n: 0,
                    exp_addr: {40'h0, 40'h0, 40'h0}, exp_len: {8'h0, 8'h0, 8'h0}};
        vecs[4] = '{addr: 40'h100F, beats: 32'd2, n: 1,
                    exp_addr: {40'h0, 40'h0, 40'h1000}, exp_len: {8'h0, 8'h0, 8'h01}};
        vecs[5] = '{addr: 40'h0FF0, beats: 32'd3, n: 2,
                    exp_addr: {40'h0, 40'h1000, 40'h0FF0}, exp_len: {8'h0, 8'h01, 8'h00}};

        reset         = 1'b1;
        s_cmd_addr    = '0;
        s_cmd_beats   = '0;
        s_cmd_valid   = 1'b0;
        m_issue_ready = 1'b0;
        s_done_valid  = 1'b0;
        repeat (3) step();

        check("rst_cmd_ready", 64'(s_cmd_ready), 64'd0);
        check("rst_issue_valid", 64'(m_issue_valid), 64'd0);
        check("rst_issue_addr", 64'(m_issue_addr), 64'd0);
        check("rst_issue_len", 64'(m_issue_len), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_job_done", 64'(job_done), 64'd0);
        check("rst_issue_cnt", 64'(issue_cnt), 64'd0);
        reset = 1'b0;
        step();

        // Table-driven jobs: each burst is accepted at once and retired the next cycle.
        for (int v = 0; v < 6; v++) begin
            do_cmd(vecs[v].addr, vecs[v].beats);
            check("busy_after_accept", 64'(busy), 64'd1);
            for (int b = 0; b < vecs[v].n; b++) begin
                wait_valid(cyc);
                if (b == 0) check("first_issue_latency", 64'(cyc), 64'd1);
                check("issue_addr", 64'(m_issue_addr), 64'(vecs[v].exp_addr[b]));
                check("issue_len", 64'(m_issue_len), 64'(vecs[v].exp_len[b]));
                $display("burst vec=%0d idx=%0d addr=0x%0h len=0x%0h", v, b, m_issue_addr, m_issue_len);
                m_issue_ready = 1'b1;
                step();
                m_issue_ready = 1'b0;
                check("cnt_after_issue", 64'(issue_cnt), 64'd1);
                done_pulse();
            end
            wait_done();
            check("busy_at_done", 64'(busy), 64'd0);
        end

        // Zero-beat job: exact job_done timing and ready re-assertion.
        do_cmd(40'h0, 32'd0);
        check("zb_done_t1", 64'(job_done), 64'd0);
        step();
        check("zb_done_t2", 64'(job_done), 64'd0);
        check("zb_valid_t2", 64'(m_issue_valid), 64'd0);
        step();
        check("zb_done_t3", 64'(job_done), 64'd1);
        check("zb_ready_t3", 64'(s_cmd_ready), 64'd0);
        step();
        check("zb_done_t4", 64'(job_done), 64'd0);
        check("zb_ready_t4", 64'(s_cmd_ready), 64'd1);
        $display("zero-beat job checked");

        // Issue limit of 2 with no completions, then one completion releases the third burst.
        do_cmd(40'h0, 32'd600);
        m_issue_ready = 1'b1;
        repeat (8) step();
        check("lim_valid_blocked", 64'(m_issue_valid), 64'd0);
        check("lim_cnt", 64'(issue_cnt), 64'd2);
        done_pulse();
        check("lim_valid_released", 64'(m_issue_valid), 64'd1);
        check("lim_cnt_after_done", 64'(issue_cnt), 64'd1);
        check("lim_addr", 64'(m_issue_addr), 64'h2000);
        check("lim_len", 64'(m_issue_len), 64'h57);
        step();
        m_issue_ready = 1'b0;
        check("lim_cnt_third", 64'(issue_cnt), 64'd2);
        s_done_valid = 1'b1;
        step();
        step();
        s_done_valid = 1'b0;
        wait_done();
        $display("issue-limit job checked");

        // Back-pressure on the second burst, then issue and completion in the same cycle.
        do_cmd(40'h1F00, 32'h40);
        wait_valid(cyc);
        check("bp_addr0", 64'(m_issue_addr), 64'h1F00);
        check("bp_len0", 64'(m_issue_len), 64'h0F);
        m_issue_ready = 1'b1;
        step();
        m_issue_ready = 1'b0;
        wait_valid(cyc);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_valid", 64'(m_issue_valid), 64'd1);
            check("bp_hold_addr", 64'(m_issue_addr), 64'h2000);
            check("bp_hold_len", 64'(m_issue_len), 64'h2F);
        end
        m_issue_ready = 1'b1;
        s_done_valid  = 1'b1;
        step();
        m_issue_ready = 1'b0;
        s_done_valid  = 1'b0;
        check("bp_cnt_simul", 64'(issue_cnt), 64'd1);
        done_pulse();
        wait_done();
        $display("back-pressure job checked");

        // Reset in the middle of a job, then a stray completion.
        do_cmd(40'h0, 32'd600);
        m_issue_ready = 1'b1;
        cyc = 0;
        while (issue_cnt != 5'd1 && cyc < 40) begin
            step();
            cyc++;
        end
        m_issue_ready = 1'b0;
        check("mr_first_issue", 64'(issue_cnt), 64'd1);
        reset = 1'b1;
        step();
        check("mr_cmd_ready", 64'(s_cmd_ready), 64'd0);
        check("mr_issue_valid", 64'(m_issue_valid), 64'd0);
        check("mr_issue_addr", 64'(m_issue_addr), 64'd0);
        check("mr_issue_len", 64'(m_issue_len), 64'd0);
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_job_done", 64'(job_done), 64'd0);
        check("mr_issue_cnt", 64'(issue_cnt), 64'd0);
        reset = 1'b0;
        done_pulse();
        check("mr_no_underflow", 64'(issue_cnt), 64'd0);
        step();
        check("mr_ready_back", 64'(s_cmd_ready), 64'd1);
        $display("mid-job reset checked");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_burst_scheduler.md
Name: dma_burst_scheduler

Overview:
- Sequences the DMA read/write core for one transfer job.
- Takes a job from the register/control side: a start address and a total beat count.
- Splits the job into AXI-legal bursts: at most MAX_BURST beats each, never crossing a 4 KB boundary.
- Issues each burst as an (addr, len) command to the DMA core's parameter port, limits outstanding bursts to ISSUE_LIMIT, and reports job completion and the live issue count.

Parameters:
- ADDR_BITS, 40, byte address width.
- BEAT_BITS, 32, width of the job total-beat count.
- AXI_LEN_BITS, 8, AXI len field width.
- SIZE, 4, log2 bytes per beat (16 B, 128-bit data).
- MAX_BURST, 256, maximum beats per burst; must be ≤ 2**AXI_LEN_BITS.
- ISSUE_LIMIT, 16, maximum bursts issued but not yet completed.
- CNT_BITS, 5, issue counter width; must satisfy ISSUE_LIMIT < 2**CNT_BITS.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- s_cmd_addr  in  ADDR_BITS  job start byte address; low SIZE bits are ignored and treated as 0
- s_cmd_beats  in  BEAT_BITS  job total beats; 0 is legal
- s_cmd_valid  in  1  job request
- s_cmd_ready  out  1  job accepted when valid & ready
- m_issue_addr  out  ADDR_BITS  burst start address
- m_issue_len  out  AXI_LEN_BITS  burst beats minus 1
- m_issue_valid  out  1  burst command valid
- m_issue_ready  in  1  DMA core accepts the burst
- s_done_valid  in  1  one-cycle pulse per completed burst from the DMA core
- busy  out  1  job in progress
- job_done  out  1  one-cycle pulse when a job fully completes
- issue_cnt  out  CNT_BITS  outstanding bursts, for the ISSUE_CNT status register

Behaviour:
- Reset values: s_cmd_ready=0, m_issue_valid=0, m_issue_addr=0, m_issue_len=0, busy=0, job_done=0, issue_cnt=0. The state machine returns to IDLE.
- Reset mid-job: the job is abandoned and all counters are cleared. Completions arriving afterwards fall under the underflow rule below.

State machine: IDLE, CALC, ISSUE, DRAIN.
- IDLE: s_cmd_ready=1. On handshake, latch cur_addr (low SIZE bits zeroed) and remaining=s_cmd_beats, then go to CALC.
- CALC: compute burst = min(remaining, MAX_BURST, bnd), where bnd = (4096 - cur_addr[11:0]) >> SIZE.
  - If remaining==0, go to DRAIN.
  - Otherwise register m_issue_addr=cur_addr and m_issue_len=burst-1, then go to ISSUE.
- ISSUE: m_issue_valid=1 only while issue_cnt < ISSUE_LIMIT.
  - Once asserted, valid, addr and len stay stable until m_issue_ready.
  - On handshake: cur_addr += burst<<SIZE, remaining -= burst, then go to CALC.
  - Throughput is therefore one burst per 2 cycles.
- DRAIN: wait until issue_cnt==0. Then pulse job_done for one cycle and go to IDLE. s_cmd_ready rises the cycle after job_done.
- Zero-beat job sequence: accept in IDLE, CALC, DRAIN, job_done. The pulse comes 3 cycles after acceptance when nothing is outstanding.
- busy=1 in every state except IDLE.

issue_cnt:
- Increments on an issue handshake and decrements on s_done_valid.
- Both in the same cycle: unchanged.
- s_done_valid while issue_cnt==0 with no handshake: ignored, the count stays 0 (no underflow).
- s_done_valid is counted in every state, including IDLE.

Latency: command handshake at cycle T gives the first m_issue_valid at T+2, provided issue_cnt < ISSUE_LIMIT.

Address arithmetic: wraps modulo 2**ADDR_BITS. Jobs must not wrap; this is not checked.

Decomposition:
- Shared package dma_sched_pkg: adr_t, beats_t, axlen_t, cnt_t typedefs; the 4 KB boundary constant (12 bits); the state enum.
- One sub-module, dma_burst_len_calc: purely combinational min(remaining, MAX_BURST, boundary beats). It is reused by the future write-side scheduler instance.

Test Plan (defaults, 16 B beats):
1. Job addr=0x1000, beats=0x100 -> one issue (0x1000, len 0xFF). Return one done pulse -> job_done, issue_cnt 1→0.
2. Job addr=0x1F00, beats=0x40 -> issues (0x1F00, len 0x0F) then (0x2000, len 0x2F). No burst crosses 0x2000.
3. Job addr=0x0, beats=600 -> issues (0x0, 0xFF), (0x1000, 0xFF), (0x2000, 0x57). job_done only after 3 done pulses.
4. ISSUE_LIMIT=2, no done pulses -> two issues, third m_issue_valid stays 0 and issue_cnt=2. One done pulse -> third issue within 1 cycle.
5. Back-pressure: m_issue_ready=0 for 5 cycles -> valid, addr and len held stable. Simultaneous issue handshake and done pulse -> issue_cnt unchanged.
6. Job beats=0 -> job_done 3 cycles after accept, no issues. Reset asserted mid-job (case 3 after the first issue) -> all outputs return to reset values the next cycle; a later done pulse leaves issue_cnt=0.
